// File: rtl/regfile_pkg.sv
// Shared constants and packing helpers for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;

    // Port idx of a packed bus lives at [sliceLo(idx, width) +: width].
    function automatic int sliceLo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard and write-collision flag for regfile_mp.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_WR-1:0]          wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
    input  logic                       sb_set_i,
    input  logic [ADDR_W-1:0]          sb_addr_i,
    output logic [(2**ADDR_W)-1:0]     busy_o,
    output logic                       wr_conflict_o
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                conflict_q;
    logic                conflict_d;
    logic [ADDR_W-1:0]   wrAddr [NUM_WR];

    always_comb begin
        for (int j = 0; j < NUM_WR; j++) begin
            wrAddr[j] = wr_addr_i[sliceLo(j, ADDR_W) +: ADDR_W];
        end
    end

    // Retiring writes clear first so that a newly issued producer to the same register wins.
    always_comb begin
        busy_d     = busy_q;
        conflict_d = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j]) begin
                busy_d[wrAddr[j]] = 1'b0;
            end
        end
        if (sb_set_i) begin
            busy_d[sb_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[REG_ZERO] = 1'b0;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (wr_en_i[j] && wr_en_i[k] && (wrAddr[j] == wrAddr[k]) &&
                    !((ZERO_REG != 0) && (wrAddr[j] == ADDR_W'(REG_ZERO)))) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign busy_o        = busy_q;
    assign wr_conflict_o = conflict_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle bypass, zero register and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_busy_o,
    input  logic [NUM_WR-1:0]          wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data_i,
    input  logic                       sb_set_i,
    input  logic [ADDR_W-1:0]          sb_addr_i,
    output logic                       wr_conflict_o
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [DATA_W-1:0]   mem_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [ADDR_W-1:0]   wrAddr [NUM_WR];
    logic [DATA_W-1:0]   wrData [NUM_WR];
    logic [NUM_WR-1:0]   wrLive;
    logic [ADDR_W-1:0]   rdAddr [NUM_RD];
    logic [DATA_W-1:0]   rdVal  [NUM_RD];
    logic [NUM_RD-1:0]   rdBsy;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .sb_set_i      (sb_set_i),
        .sb_addr_i     (sb_addr_i),
        .busy_o        (busy),
        .wr_conflict_o (wr_conflict_o)
    );

    // A write is live only if enabled and not aimed at the hard-wired zero register.
    always_comb begin
        for (int j = 0; j < NUM_WR; j++) begin
            wrAddr[j] = wr_addr_i[sliceLo(j, DATA_W) / DATA_W * ADDR_W +: ADDR_W];
            wrData[j] = wr_data_i[sliceLo(j, DATA_W) +: DATA_W];
            wrLive[j] = wr_en_i[j] &&
                        !((ZERO_REG != 0) && (wrAddr[j] == ADDR_W'(REG_ZERO)));
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            mem_d[r] = mem_q[r];
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (wrLive[j]) begin
                mem_d[wrAddr[j]] = wrData[j];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    // Later write ports override earlier ones, matching the storage priority.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rdAddr[i] = rd_addr_i[sliceLo(i, ADDR_W) +: ADDR_W];
            rdVal[i]  = mem_q[rdAddr[i]];
            rdBsy[i]  = busy[rdAddr[i]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wrLive[j] && (wrAddr[j] == rdAddr[i])) begin
                        rdVal[i] = wrData[j];
                        rdBsy[i] = 1'b0;
                    end
                end
            end
            if ((ZERO_REG != 0) && (rdAddr[i] == ADDR_W'(REG_ZERO))) begin
                rdVal[i] = '0;
                rdBsy[i] = 1'b0;
            end
            rd_data_o[sliceLo(i, DATA_W) +: DATA_W] = rdVal[i];
            rd_busy_o[i] = rdBsy[i];
        end
    end

endmodule
